fifo_rd_packer: RTL and testbench

//  Downstream consumer of the synchronous FIFO. Issues rd_en to the FIFO without ever underflowing it.

---
 rtl/fifo_rd_packer.sv | 115 +++++++++++
 tb/tb_fifo_rd_packer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_packer.sv
// Read-side consumer of a synchronous FIFO: pops words without underflow, stages them,
// and packs pairs into 2*FIFO_WIDTH beats; a flush drains an odd trailing word as a half beat.
module fifo_rd_packer #(
  parameter int FIFO_WIDTH  = 16,
  parameter int STAGE_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [FIFO_WIDTH-1:0]   fifo_dout,
  input  logic                    fifo_empty,
  output logic                    fifo_rd_en,
  input  logic                    flush,
  output logic [2*FIFO_WIDTH-1:0] pk_data,
  output logic [1:0]              pk_keep,
  output logic                    pk_valid,
  input  logic                    pk_ready,
  output logic                    flush_done,
  output logic [0:0]              dbg_state_o
);

  localparam int PW = $clog2(STAGE_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_C = STAGE_DEPTH[CW:0];

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_DRAIN = 1'b1;

  logic [FIFO_WIDTH-1:0] stage_q [STAGE_DEPTH];
  logic [PW-1:0]         wr_ptr_q;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d, rd_ptr_p1;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [CW-1:0]         pop_n;
  logic [CW:0]           occ;
  logic                  rd_pend_q;
  logic [0:0]            state_q, state_d;
  logic                  flush_busy;
  logic                  full_avail, partial_avail, pk_hs;

  assign flush_busy  = (state_q == ST_DRAIN);
  assign dbg_state_o = state_q;

  // Occupancy counts the word already requested but not yet captured, so the
  // staging slots can never be oversubscribed.
  assign occ        = {1'b0, cnt_q} + (CW+1)'(rd_pend_q);
  assign fifo_rd_en = rst_n && !fifo_empty && !flush_busy && (occ < DEPTH_C);

  // Stream handshake: a beat transfers on a cycle where pk_valid && pk_ready;
  // while pk_valid is high and pk_ready low, pk_data/pk_keep stay unchanged and
  // pk_valid stays high until the transfer happens.
  assign full_avail    = (cnt_q >= CW'(2));
  assign partial_avail = flush_busy && (cnt_q == CW'(1)) && !rd_pend_q;
  assign pk_valid      = full_avail || partial_avail;
  assign pk_hs         = pk_valid && pk_ready;

  assign rd_ptr_p1 = rd_ptr_q + PW'(1);

  always_comb begin
    pk_data = '0;
    pk_keep = 2'b00;
    if (full_avail) begin
      pk_data = {stage_q[rd_ptr_p1], stage_q[rd_ptr_q]};
      pk_keep = 2'b11;
    end else if (partial_avail) begin
      pk_data = {{FIFO_WIDTH{1'b0}}, stage_q[rd_ptr_q]};
      pk_keep = 2'b01;
    end
  end

  always_comb begin
    pop_n = '0;
    if (pk_hs) begin
      pop_n = full_avail ? CW'(2) : CW'(1);
    end
  end

  assign cnt_d    = cnt_q + CW'(rd_pend_q) - pop_n;
  assign rd_ptr_d = rd_ptr_q + pop_n[PW-1:0];

  assign flush_done = flush_busy && (cnt_q == '0) && !rd_pend_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (flush) state_d = ST_DRAIN;
      ST_DRAIN: if (flush_done) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      rd_pend_q <= 1'b0;
      state_q   <= ST_IDLE;
    end else begin
      rd_pend_q <= fifo_rd_en;
      cnt_q     <= cnt_d;
      rd_ptr_q  <= rd_ptr_d;
      state_q   <= state_d;
      if (rd_pend_q) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
    end
  end

  // Data slots carry no reset; their contents only matter while counted in cnt_q.
  always_ff @(posedge clk) begin
    if (rd_pend_q) begin
      stage_q[wr_ptr_q] <= fifo_dout;
    end
  end

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Directed bench for fifo_rd_packer: a queue-backed FIFO model feeds the packer and
// each scenario task checks its outputs against hand-computed values.
module tb_fifo_rd_packer;
  localparam int W = 16;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [W-1:0]   fifo_dout;
  logic           fifo_empty = 1'b1;
  logic           fifo_rd_en;
  logic           flush;
  logic [2*W-1:0] pk_data;
  logic [1:0]     pk_keep;
  logic           pk_valid;
  logic           pk_ready;
  logic           flush_done;
  logic [0:0]     dbg_state;

  logic [W-1:0]   fifo_q[$];
  logic [2*W-1:0] exp_q[$];
  int chk_cnt = 0;
  int pass_cnt = 0;
  int underflow_cnt = 0;

  // clock / reset
  always #5 clk = ~clk;

  fifo_rd_packer #(.FIFO_WIDTH(W), .STAGE_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .fifo_dout(fifo_dout), .fifo_empty(fifo_empty),
    .fifo_rd_en(fifo_rd_en), .flush(flush), .pk_data(pk_data), .pk_keep(pk_keep),
    .pk_valid(pk_valid), .pk_ready(pk_ready), .flush_done(flush_done),
    .dbg_state_o(dbg_state)
  );

  // FIFO model: registered read data, empty flag refreshed just after each edge
  always @(posedge clk) begin
    if (fifo_rd_en) begin
      if (fifo_q.size() == 0) underflow_cnt++;
      else fifo_dout <= fifo_q.pop_front();
    end
  end

  always @(posedge clk) begin
    #2;
    fifo_empty = (fifo_q.size() == 0);
  end

  // driver tasks
  task automatic drive_point();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive_point();
    rst_n = 1'b0;
    flush = 1'b0;
    pk_ready = 1'b0;
    fifo_q.delete();
    exp_q.delete();
    drive_point();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    chk_cnt++; if (pk_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", pk_valid); else pass_cnt++;
    chk_cnt++; if (pk_keep !== 2'b00) $display("FAIL rst_keep: got %b want 00", pk_keep); else pass_cnt++;
    chk_cnt++; if (pk_data !== 32'h0) $display("FAIL rst_data: got %h want 0", pk_data); else pass_cnt++;
    chk_cnt++; if (fifo_rd_en !== 1'b0) $display("FAIL rst_rd_en: got %b want 0", fifo_rd_en); else pass_cnt++;
    chk_cnt++; if (flush_done !== 1'b0) $display("FAIL rst_flush_done: got %b want 0", flush_done); else pass_cnt++;
    drive_point();
    rst_n = 1'b1;
    pk_ready = 1'b0;
    fifo_q.push_back(16'h0001);
    fifo_q.push_back(16'h0002);
    fifo_q.push_back(16'h0003);
    repeat (4) @(negedge clk);
    chk_cnt++; if (pk_valid !== 1'b1) $display("FAIL rst_pre_valid: got %b want 1", pk_valid); else pass_cnt++;
    drive_point();
    rst_n = 1'b0;
    fifo_q.push_back(16'h0004);
    #1;
    chk_cnt++; if (pk_valid !== 1'b0) $display("FAIL rst_async_valid: got %b want 0", pk_valid); else pass_cnt++;
    chk_cnt++; if (pk_data !== 32'h0) $display("FAIL rst_async_data: got %h want 0", pk_data); else pass_cnt++;
    chk_cnt++; if (pk_keep !== 2'b00) $display("FAIL rst_async_keep: got %b want 00", pk_keep); else pass_cnt++;
    chk_cnt++; if (fifo_rd_en !== 1'b0) $display("FAIL rst_async_rd_en: got %b want 0", fifo_rd_en); else pass_cnt++;
    fifo_q.delete();
    drive_point();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk_cnt++; if (pk_valid !== 1'b0) $display("FAIL rst_stale_valid: cycle %0d got %b want 0", i, pk_valid); else pass_cnt++;
    end
    drive_point();
  endtask

  task automatic test_pairing();
    do_reset();
    pk_ready = 1'b1;
    fifo_q.push_back(16'hAAAA);
    fifo_q.push_back(16'hBBBB);
    @(negedge clk);
    chk_cnt++; if (fifo_rd_en !== 1'b1) $display("FAIL pair_first_rd_en: got %b want 1", fifo_rd_en); else pass_cnt++;
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      chk_cnt++; if (pk_valid !== 1'b0) $display("FAIL pair_early_valid: cycle %0d got %b want 0", k, pk_valid); else pass_cnt++;
    end
    @(negedge clk);
    chk_cnt++; if (pk_valid !== 1'b1) $display("FAIL pair_valid: got %b want 1", pk_valid); else pass_cnt++;
    chk_cnt++; if (pk_data !== 32'hBBBB_AAAA) $display("FAIL pair_data: got %h want bbbbaaaa", pk_data); else pass_cnt++;
    chk_cnt++; if (pk_keep !== 2'b11) $display("FAIL pair_keep: got %b want 11", pk_keep); else pass_cnt++;
    @(negedge clk);
    chk_cnt++; if (pk_valid !== 1'b0) $display("FAIL pair_after_valid: got %b want 0", pk_valid); else pass_cnt++;
    drive_point();
  endtask

  task automatic test_underflow();
    do_reset();
    pk_ready = 1'b1;
    fifo_q.push_back(16'h0001);
    fifo_q.push_back(16'h0002);
    fifo_q.push_back(16'h0003);
    repeat (4) @(negedge clk);
    chk_cnt++; if (pk_valid !== 1'b1) $display("FAIL uf_valid: got %b want 1", pk_valid); else pass_cnt++;
    chk_cnt++; if (pk_data !== 32'h0002_0001) $display("FAIL uf_data: got %h want 00020001", pk_data); else pass_cnt++;
    for (int k = 4; k < 8; k++) begin
      @(negedge clk);
      chk_cnt++; if (fifo_rd_en !== 1'b0) $display("FAIL uf_rd_en: cycle %0d got %b want 0", k, fifo_rd_en); else pass_cnt++;
      chk_cnt++; if (pk_valid !== 1'b0) $display("FAIL uf_held_valid: cycle %0d got %b want 0", k, pk_valid); else pass_cnt++;
    end
    chk_cnt++; if (underflow_cnt !== 0) $display("FAIL uf_no_underflow: got %0d want 0", underflow_cnt); else pass_cnt++;
    drive_point();
    flush = 1'b1;
    drive_point();
    flush = 1'b0;
    @(negedge clk);
    chk_cnt++; if (pk_valid !== 1'b1) $display("FAIL uf_tail_valid: got %b want 1", pk_valid); else pass_cnt++;
    chk_cnt++; if (pk_data !== 32'h0000_0003) $display("FAIL uf_tail_data: got %h want 00000003", pk_data); else pass_cnt++;
    chk_cnt++; if (pk_keep !== 2'b01) $display("FAIL uf_tail_keep: got %b want 01", pk_keep); else pass_cnt++;
    @(negedge clk);
    chk_cnt++; if (flush_done !== 1'b1) $display("FAIL uf_tail_done: got %b want 1", flush_done); else pass_cnt++;
    drive_point();
  endtask

  task automatic test_flush_tail();
    do_reset();
    pk_ready = 1'b1;
    fifo_q.push_back(16'h1234);
    repeat (3) @(negedge clk);
    chk_cnt++; if (pk_valid !== 1'b0) $display("FAIL ft_single_valid: got %b want 0", pk_valid); else pass_cnt++;
    drive_point();
    flush = 1'b1;
    drive_point();
    flush = 1'b0;
    @(negedge clk);
    chk_cnt++; if (pk_valid !== 1'b1) $display("FAIL ft_valid: got %b want 1", pk_valid); else pass_cnt++;
    chk_cnt++; if (pk_data !== 32'h0000_1234) $display("FAIL ft_data: got %h want 00001234", pk_data); else pass_cnt++;
    chk_cnt++; if (pk_keep !== 2'b01) $display("FAIL ft_keep: got %b want 01", pk_keep); else pass_cnt++;
    chk_cnt++; if (flush_done !== 1'b0) $display("FAIL ft_early_done: got %b want 0", flush_done); else pass_cnt++;
    @(negedge clk);
    chk_cnt++; if (flush_done !== 1'b1) $display("FAIL ft_done: got %b want 1", flush_done); else pass_cnt++;
    chk_cnt++; if (pk_valid !== 1'b0) $display("FAIL ft_post_valid: got %b want 0", pk_valid); else pass_cnt++;
    @(negedge clk);
    chk_cnt++; if (flush_done !== 1'b0) $display("FAIL ft_done_pulse: got %b want 0", flush_done); else pass_cnt++;
    drive_point();
    flush = 1'b1;
    drive_point();
    flush = 1'b0;
    @(negedge clk);
    chk_cnt++; if (flush_done !== 1'b1) $display("FAIL ft_empty_done: got %b want 1", flush_done); else pass_cnt++;
    @(negedge clk);
    chk_cnt++; if (flush_done !== 1'b0) $display("FAIL ft_empty_pulse: got %b want 0", flush_done); else pass_cnt++;
    drive_point();
  endtask

  task automatic test_backpressure();
    int budget;
    do_reset();
    pk_ready = 1'b0;
    for (int i = 0; i < 6; i++) fifo_q.push_back(16'h0010 + 16'(i));
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k >= 4) begin
        chk_cnt++; if (fifo_rd_en !== 1'b0) $display("FAIL bp_rd_en: cycle %0d got %b want 0", k, fifo_rd_en); else pass_cnt++;
      end
      if (k >= 3) begin
        chk_cnt++; if (pk_valid !== 1'b1 || pk_data !== 32'h0011_0010)
          $display("FAIL bp_hold: cycle %0d got valid=%b data=%h want valid=1 data=00110010", k, pk_valid, pk_data);
        else pass_cnt++;
      end
    end
    drive_point();
    pk_ready = 1'b1;
    exp_q.push_back(32'h0011_0010);
    exp_q.push_back(32'h0013_0012);
    exp_q.push_back(32'h0015_0014);
    budget = 0;
    while (exp_q.size() != 0 && budget < 40) begin
      @(negedge clk);
      budget++;
      if (pk_valid && pk_ready) begin
        chk_cnt++; if (pk_data !== exp_q[0] || pk_keep !== 2'b11)
          $display("FAIL bp_beat: got %h/%b want %h/11", pk_data, pk_keep, exp_q[0]);
        else pass_cnt++;
        void'(exp_q.pop_front());
      end
    end
    chk_cnt++; if (exp_q.size() != 0) $display("FAIL bp_timeout: %0d beats missing want 0", exp_q.size()); else pass_cnt++;
    @(negedge clk);
    chk_cnt++; if (pk_valid !== 1'b0) $display("FAIL bp_drained_valid: got %b want 0", pk_valid); else pass_cnt++;
    drive_point();
  endtask

  task automatic test_stream();
    int budget;
    int beats;
    do_reset();
    for (int i = 0; i < 64; i++) fifo_q.push_back(16'(i));
    for (int k = 0; k < 32; k++) exp_q.push_back({16'(2*k+1), 16'(2*k)});
    budget = 0;
    beats = 0;
    while (exp_q.size() != 0 && budget < 600) begin
      pk_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      budget++;
      if (pk_valid && pk_ready) begin
        beats++;
        chk_cnt++; if (pk_data !== exp_q[0] || pk_keep !== 2'b11)
          $display("FAIL stream_beat%0d: got %h/%b want %h/11", beats, pk_data, pk_keep, exp_q[0]);
        else pass_cnt++;
        void'(exp_q.pop_front());
      end
      drive_point();
    end
    chk_cnt++; if (beats != 32) $display("FAIL stream_count: got %0d beats want 32", beats); else pass_cnt++;
    pk_ready = 1'b1;
    repeat (4) @(negedge clk);
    chk_cnt++; if (pk_valid !== 1'b0) $display("FAIL stream_extra_valid: got %b want 0", pk_valid); else pass_cnt++;
    chk_cnt++; if (underflow_cnt !== 0) $display("FAIL stream_underflow: got %0d want 0", underflow_cnt); else pass_cnt++;
    drive_point();
  endtask

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    pk_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_pairing();
    test_underflow();
    test_flush_tail();
    test_backpressure();
    test_stream();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
